flex_counter_multi: RTL and testbench

//  Parametrised multi-channel up/down flex counter, successor to the single 7-bit flex counter.

---
 rtl/flex_counter_multi.sv | 116 +++++++++++
 tb/tb_flex_counter_multi.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/flex_counter_multi.sv
// Multi-channel up/down flex counter with seed load, clear, programmable rollover and optional cascade.
// Define FLEX_CNT_SATURATE_EN to make channels saturate at their bounds instead of wrapping.
module flex_counter_multi #(
  parameter int NUM_CH  = 2,
  parameter int WIDTH   = 7,
  parameter int CASCADE = 0
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH-1:0]       count_enable,
  input  logic [NUM_CH-1:0]       sign,
  input  logic [NUM_CH*WIDTH-1:0] seed,
  input  logic [NUM_CH*WIDTH-1:0] rollover_val,
  output logic [NUM_CH*WIDTH-1:0] count_out,
  output logic [NUM_CH-1:0]       rollover_flag,
  output logic                    any_rollover
);

  logic [NUM_CH-1:0] wrap;
  logic              any_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi = gi + 1) begin : g_ch
      logic [WIDTH-1:0] count_reg;
      logic [WIDTH-1:0] count_next;
      logic [WIDTH-1:0] r_val;
      logic             flag_reg;
      logic             flag_next;
      logic             wrap_c;
      logic             en_c;

      assign r_val = rollover_val[gi*WIDTH +: WIDTH];

      // Each channel keeps its own wrap net so the cascade chain stays acyclic per bit.
      if (CASCADE != 0 && gi > 0) begin : g_casc
        assign en_c = count_enable[gi] & g_ch[gi-1].wrap_c;
      end else begin : g_solo
        assign en_c = count_enable[gi];
      end

      always_comb begin
        count_next = count_reg;
        wrap_c     = 1'b0;
        flag_next  = 1'b0;
        if (clear[gi]) begin
          count_next = '0;
        end else if (load[gi]) begin
          count_next = seed[gi*WIDTH +: WIDTH];
        end else if (en_c) begin
`ifdef FLEX_CNT_SATURATE_EN
          if (!sign[gi]) begin
            count_next = (count_reg >= r_val) ? r_val : count_reg + 1'b1;
            flag_next  = (count_next == r_val);
          end else begin
            if (count_reg == '0)
              count_next = '0;
            else if (count_reg > r_val)
              count_next = r_val;
            else
              count_next = count_reg - 1'b1;
            flag_next = (count_next == '0);
          end
          // Only the first arrival at the bound counts as a wrap event.
          wrap_c = flag_next && (count_next != count_reg);
`else
          if (!sign[gi]) begin
            if (count_reg >= r_val) begin
              count_next = '0;
              wrap_c     = 1'b1;
            end else begin
              count_next = count_reg + 1'b1;
            end
          end else begin
            if (count_reg == '0) begin
              count_next = r_val;
              wrap_c     = 1'b1;
            end else if (count_reg > r_val) begin
              count_next = r_val;
            end else begin
              count_next = count_reg - 1'b1;
            end
          end
          flag_next = wrap_c;
`endif
        end
      end

      always_ff @(posedge clk) begin
        if (!n_rst) begin
          count_reg <= '0;
          flag_reg  <= 1'b0;
        end else begin
          count_reg <= count_next;
          flag_reg  <= flag_next;
        end
      end

      assign wrap[gi]                      = wrap_c;
      assign count_out[gi*WIDTH +: WIDTH]  = count_reg;
      assign rollover_flag[gi]             = flag_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!n_rst)
      any_reg <= 1'b0;
    else
      any_reg <= |wrap;
  end

  assign any_rollover = any_reg;

endmodule

// File: tb/tb_flex_counter_multi.sv
// Directed bench for flex_counter_multi: vector table on a 2-channel instance, plus reset and cascade sequences.
module tb_flex_counter_multi;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [1:0]  clear, load, count_enable, sign;
  logic [13:0] seed, rollover_val;
  logic [13:0] count_out;
  logic [1:0]  rollover_flag;
  logic        any_rollover;

  logic [1:0]  c_clear, c_load, c_enable, c_sign;
  logic [13:0] c_seed, c_rval;
  logic [13:0] c_count;
  logic [1:0]  c_flag;
  logic        c_any;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  flex_counter_multi #(.NUM_CH(2), .WIDTH(7), .CASCADE(0)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .load(load), .count_enable(count_enable),
    .sign(sign), .seed(seed), .rollover_val(rollover_val), .count_out(count_out),
    .rollover_flag(rollover_flag), .any_rollover(any_rollover)
  );

  flex_counter_multi #(.NUM_CH(2), .WIDTH(7), .CASCADE(1)) dut_c (
    .clk(clk), .n_rst(n_rst), .clear(c_clear), .load(c_load), .count_enable(c_enable),
    .sign(c_sign), .seed(c_seed), .rollover_val(c_rval), .count_out(c_count),
    .rollover_flag(c_flag), .any_rollover(c_any)
  );

  typedef struct {
    logic [1:0] clr, ld, en, sg;
    logic [6:0] seed0, r0, seed1, r1;
    logic [6:0] e0, e1;
    logic [1:0] ef;
    logic       eany;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit c0, bit l0, bit n0, bit s0, int sd0, int r0,
                              bit c1, bit l1, bit n1, bit s1, int sd1, int r1,
                              int x0, int x1, bit f0, bit f1, bit any);
    vec_t v;
    v.clr   = {c1, c0};
    v.ld    = {l1, l0};
    v.en    = {n1, n0};
    v.sg    = {s1, s0};
    v.seed0 = 7'(sd0);
    v.r0    = 7'(r0);
    v.seed1 = 7'(sd1);
    v.r1    = 7'(r1);
    v.e0    = 7'(x0);
    v.e1    = 7'(x1);
    v.ef    = {f1, f0};
    v.eany  = any;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    clear        = v.clr;
    load         = v.ld;
    count_enable = v.en;
    sign         = v.sg;
    seed         = {v.seed1, v.seed0};
    rollover_val = {v.r1, v.r0};
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check("cnt0", i, 32'(count_out[6:0]), 32'(vecs[i].e0));
      check("cnt1", i, 32'(count_out[13:7]), 32'(vecs[i].e1));
      check("flag", i, 32'(rollover_flag), 32'(vecs[i].ef));
      check("any",  i, 32'(any_rollover), 32'(vecs[i].eany));
      $display("vec %0d: cnt=%0d/%0d flag=%b any=%b", i, count_out[6:0], count_out[13:7],
               rollover_flag, any_rollover);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    clear = '0; load = '0; count_enable = 2'b11; sign = '0;
    seed = {7'd33, 7'd44}; rollover_val = {7'd9, 7'd9};
    c_clear = '0; c_load = '0; c_enable = 2'b11; c_sign = '0;
    c_seed = '0; c_rval = {7'd9, 7'd9};

    // Reset held for two edges with enables active.
    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt", 0, 32'(count_out), 32'd0);
    check("rst_flag", 0, 32'(rollover_flag), 32'd0);
    check("rst_any", 0, 32'(any_rollover), 32'd0);
    check("rst_ccnt", 0, 32'(c_count), 32'd0);
    check("rst_cflag", 0, 32'(c_flag), 32'd0);
    $display("reset: cnt=%0d ccnt=%0d", count_out, c_count);

    @(negedge clk);
    n_rst = 1'b1;
    count_enable = '0;
    c_enable = '0;

`ifndef FLEX_CNT_SATURATE_EN
    // Up wrap on ch0 (R=5) alongside a down wrap on ch1 (R=2).
    vecs.push_back(mk(0,0,1,0,0,5,   0,0,1,1,0,2,    1,2,0,1,1));
    vecs.push_back(mk(0,0,1,0,0,5,   0,0,1,1,0,2,    2,1,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,5,   0,0,1,1,0,2,    3,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,5,   0,0,1,1,0,2,    4,2,0,1,1));
    vecs.push_back(mk(0,0,1,0,0,5,   0,0,1,1,0,2,    5,1,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,5,   0,0,1,1,0,2,    0,0,1,0,1));
    vecs.push_back(mk(0,0,1,0,0,5,   0,0,0,0,0,2,    1,0,0,0,0));
    // Down from seed 3 with R=9, then lower R below the count.
    vecs.push_back(mk(0,1,1,1,3,9,   0,0,0,0,0,0,    3,0,0,0,0));
    vecs.push_back(mk(0,0,1,1,0,9,   0,0,0,0,0,0,    2,0,0,0,0));
    vecs.push_back(mk(0,0,1,1,0,9,   0,0,0,0,0,0,    1,0,0,0,0));
    vecs.push_back(mk(0,0,1,1,0,9,   0,0,0,0,0,0,    0,0,0,0,0));
    vecs.push_back(mk(0,0,1,1,0,9,   0,0,0,0,0,0,    9,0,1,0,1));
    vecs.push_back(mk(0,0,1,1,0,4,   0,0,0,0,0,0,    4,0,0,0,0));
    vecs.push_back(mk(0,0,1,1,0,4,   0,0,0,0,0,0,    3,0,0,0,0));
    // Priority on ch0; R=0 on ch1 wraps every enabled cycle in both directions.
    vecs.push_back(mk(1,1,1,0,50,4,  0,0,1,0,0,0,    0,0,0,1,1));
    vecs.push_back(mk(0,1,1,0,7,9,   0,0,1,1,0,0,    7,0,0,1,1));
    // Seed above R is kept, then wraps at once going up.
    vecs.push_back(mk(0,0,0,0,0,9,   0,1,0,0,100,50, 7,100,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,9,   0,0,1,0,0,50,   8,0,0,1,1));
    // Full-range ch0 and a down wrap to R on ch1.
    vecs.push_back(mk(0,1,0,0,126,127, 0,0,1,1,0,50, 126,50,0,1,1));
    vecs.push_back(mk(0,0,1,0,0,127, 0,0,1,1,0,50,   127,49,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,127, 1,0,1,1,0,50,   0,0,1,0,1));
    vecs.push_back(mk(0,0,1,1,0,127, 0,1,1,1,5,3,    127,5,1,0,1));
    vecs.push_back(mk(0,0,1,1,0,127, 0,0,1,1,0,3,    126,3,0,0,0));
    // Set up ch0 one step short of a wrap for the reset sequence below.
    vecs.push_back(mk(0,1,0,0,0,1,   0,0,0,0,0,0,    0,3,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,1,   0,0,0,0,0,0,    1,3,0,0,0));
    run_table();

    // Reset on the edge that would have wrapped: no pulse may survive.
    @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_cnt", 0, 32'(count_out), 32'd0);
    check("midrst_flag", 0, 32'(rollover_flag), 32'd0);
    check("midrst_any", 0, 32'(any_rollover), 32'd0);
    $display("mid reset: cnt=%0d flag=%b any=%b", count_out, rollover_flag, any_rollover);
    @(negedge clk);
    n_rst = 1'b1;
    count_enable = '0;
    @(posedge clk);
    #1;
    check("postrst_flag", 0, 32'(rollover_flag), 32'd0);
    check("postrst_cnt", 0, 32'(count_out), 32'd0);
    $display("post reset: cnt=%0d flag=%b", count_out, rollover_flag);

    // Two-digit decade counter through the cascade instance.
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    c_enable = 2'b11;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      check("c_cnt0", k, 32'(c_count[6:0]), 32'(k % 10));
      check("c_cnt1", k, 32'(c_count[13:7]), 32'((k / 10) % 10));
      check("c_flag0", k, 32'(c_flag[0]), 32'(k % 10 == 0));
      check("c_flag1", k, 32'(c_flag[1]), 32'(k % 100 == 0));
      check("c_any", k, 32'(c_any), 32'(k % 10 == 0));
      $display("cascade clk %0d: ch1=%0d ch0=%0d flag=%b any=%b", k, c_count[13:7],
               c_count[6:0], c_flag, c_any);
    end
    c_enable = '0;
`else
    // Saturating up to R=3, then reverse and saturate down at 0.
    vecs.push_back(mk(0,0,1,0,0,3,   0,0,0,0,0,0,    1,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,3,   0,0,0,0,0,0,    2,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,3,   0,0,0,0,0,0,    3,0,1,0,1));
    vecs.push_back(mk(0,0,1,0,0,3,   0,0,0,0,0,0,    3,0,1,0,0));
    vecs.push_back(mk(0,0,1,0,0,3,   0,0,0,0,0,0,    3,0,1,0,0));
    vecs.push_back(mk(0,0,1,1,0,3,   0,0,0,0,0,0,    2,0,0,0,0));
    vecs.push_back(mk(0,0,1,1,0,3,   0,0,0,0,0,0,    1,0,0,0,0));
    vecs.push_back(mk(0,0,1,1,0,3,   0,0,0,0,0,0,    0,0,1,0,1));
    vecs.push_back(mk(0,0,1,1,0,3,   0,0,0,0,0,0,    0,0,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,3,   0,0,0,0,0,0,    0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,3,3,   0,0,0,0,0,0,    3,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,3,   0,0,0,0,0,0,    3,0,1,0,0));
    vecs.push_back(mk(1,0,1,0,0,3,   0,0,0,0,0,0,    0,0,0,0,0));
    run_table();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
